// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and constants for the memory slave and its helpers.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_t;

    // True when the low address bits are zero for a 2^size-byte access.
    function automatic logic is_aligned(input logic [2:0] size, input logic [7:0] addr_lo);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i < int'(size)) && addr_lo[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/ahb_lite_byte_mask.sv
// Byte-lane enable generator: a 2^size-byte run shifted to the lane of the
// low address bits, little-endian lane numbering.
module ahb_lite_byte_mask
    import ahb_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned LANE_BITS = $clog2(STRB_W)
) (
    input  logic [2:0]           i_size,
    input  logic [LANE_BITS-1:0] i_addr_lo,
    output logic [STRB_W-1:0]    o_mask_c
);

    logic [STRB_W-1:0] w_len;

    always_comb begin
        w_len = '0;
        case (i_size)
            HSIZE_BYTE:  w_len = STRB_W'(8'h01);
            HSIZE_HALF:  w_len = STRB_W'(8'h03);
            HSIZE_WORD:  w_len = STRB_W'(8'h0F);
            HSIZE_DWORD: w_len = STRB_W'(8'hFF);
            default:     w_len = '0;
        endcase
    end

    assign o_mask_c = w_len << i_addr_lo;

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite slave with word-addressed register memory, wait states and ERROR response.
// Optional privileged top-quarter region when AHB_LITE_PROT_EN is defined.
module ahb_lite_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned LANE_BITS  = $clog2(STRB_W);
    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned AW_USED    = LANE_BITS + IDX_W;
    localparam int unsigned BYTE_RANGE = DEPTH_WORDS * STRB_W;
    localparam int unsigned CNT_W      = 4;

    slave_state_t         r_state;
    slave_state_t         w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_hreadyout;
    logic                 w_hreadyout_nxt;
    logic                 r_hresp;
    logic                 w_hresp_nxt;
    logic                 w_load;

    logic [AW_USED-1:0]   r_addr;
    logic                 r_write;
    logic [2:0]           r_size;

    htrans_t              w_trans;
    logic                 w_accept;
    logic                 w_range_ok;
    logic                 w_align_ok;
    logic                 w_size_ok;
    logic                 w_prot_ok;
    logic                 w_legal;

    logic [STRB_W-1:0]    w_mask;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_do_write;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Address-phase qualification and legality of the incoming transfer
    assign w_trans    = htrans_t'(HTRANS);
    assign w_accept   = HSEL && HREADY && ((w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ));
    assign w_range_ok = 64'(HADDR) < 64'(BYTE_RANGE);
    assign w_align_ok = is_aligned(HSIZE, 8'(HADDR[LANE_BITS-1:0]));
    assign w_size_ok  = HSIZE <= 3'(LANE_BITS);

`ifdef AHB_LITE_PROT_EN
    localparam int unsigned PRIV_BASE = BYTE_RANGE - (BYTE_RANGE / 4);
    logic w_unused;
    assign w_prot_ok = HPROT[1] || (64'(HADDR) < 64'(PRIV_BASE));
    assign w_unused  = ^{HBURST, HPROT[3:2], HPROT[0]};
`else
    logic w_unused;
    assign w_prot_ok = 1'b1;
    assign w_unused  = ^{HBURST, HPROT};
`endif

    assign w_legal = w_range_ok && w_align_ok && w_size_ok && w_prot_ok;

    // Next state, wait counter and the registered response for the entered state
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_load          = 1'b0;
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = HRESP_OKAY;

        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (!w_legal) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        case (w_state_nxt)
            ST_WAIT: w_hreadyout_nxt = 1'b0;
            ST_ERR1: begin
                w_hreadyout_nxt = 1'b0;
                w_hresp_nxt     = HRESP_ERROR;
            end
            ST_ERR2: w_hresp_nxt = HRESP_ERROR;
            default: w_hreadyout_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
            if (w_load) begin
                r_addr  <= HADDR[AW_USED-1:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    ahb_lite_byte_mask #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_mask (
        .i_size    (r_size),
        .i_addr_lo (r_addr[LANE_BITS-1:0]),
        .o_mask_c  (w_mask)
    );

    assign w_idx      = r_addr[AW_USED-1:LANE_BITS];
    assign w_do_write = (r_state == ST_DATA) && r_write && !HRESET;

    // Memory has no reset; a reset in the data phase suppresses the commit
    always_ff @(posedge HCLK) begin
        if (w_do_write) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (w_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA    = ((r_state == ST_DATA) && !r_write) ? r_mem[w_idx] : '0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench: two slaves (0 and 2 wait states) driven by a pipelined
// master and compared against a byte-array reference model.
module tb_ahb_lite_mem_slave;

    typedef struct packed {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [3:0]  hprot  [2];
    logic [31:0] hwdata [2];

    logic [31:0] hrdata_0, hrdata_1;
    logic        hro_0, hro_1, hresp_0, hresp_1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [2][1024];
    int          res_low  [$];
    logic        res_errl [$];
    logic        res_errf [$];
    logic [31:0] res_rd   [$];

    ahb_lite_mem_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]),
        .HPROT(hprot[0]), .HREADY(hro_0), .HWDATA(hwdata[0]), .HRDATA(hrdata_0),
        .HREADYOUT(hro_0), .HRESP(hresp_0)
    );

    ahb_lite_mem_slave #(.WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]),
        .HPROT(hprot[1]), .HREADY(hro_1), .HWDATA(hwdata[1]), .HRDATA(hrdata_1),
        .HREADYOUT(hro_1), .HRESP(hresp_1)
    );

    function automatic xfer_t mk(input logic [1:0] t, input logic w, input logic [31:0] a,
                                 input logic [2:0] s, input logic [31:0] wd);
        xfer_t x;
        x.trans = t; x.write = w; x.addr = a; x.size = s;
        x.burst = 3'd0; x.prot = 4'b0011; x.wdata = wd;
        return x;
    endfunction

    // Reference: legality rules, response shape and byte-array memory update
    function automatic void model_apply(input int d, input xfer_t x, output int e_low,
                                        output logic e_err, output logic [31:0] e_rd);
        int nb, lane, base;
        logic ill;
        e_low = 0; e_err = 1'b0; e_rd = 32'h0;
        if (!x.trans[1]) return;
        nb  = 1 << x.size;
        ill = (x.addr >= 1024) || (nb > 4) || ((x.addr % nb) != 0);
`ifdef AHB_LITE_PROT_EN
        if ((x.addr >= 768) && !x.prot[1]) ill = 1'b1;
`endif
        if (ill) begin
            e_low = 1; e_err = 1'b1;
            return;
        end
        e_low = (d == 0) ? 0 : 2;
        base  = int'(x.addr) & ~3;
        if (x.write) begin
            for (int k = 0; k < nb; k++) begin
                lane = int'(x.addr % 4) + k;
                ref_mem[d][int'(x.addr) + k] = x.wdata[8*lane +: 8];
            end
        end else begin
            for (int b = 0; b < 4; b++) e_rd[8*b +: 8] = ref_mem[d][base + b];
        end
    endfunction

    // Pipelined master: issues q in order on slave d, records per-transfer response
    task automatic run_seq(input int d, input xfer_t q[$]);
        int n, ap, dp, guard, limit;
        logic rdy, rsp;
        logic [31:0] rd;
        n = q.size();
        res_low.delete(); res_errl.delete(); res_errf.delete(); res_rd.delete();
        for (int i = 0; i < n; i++) begin
            res_low.push_back(0); res_errl.push_back(1'b0);
            res_errf.push_back(1'b0); res_rd.push_back(32'h0);
        end
        ap = 0; dp = -1; guard = 0; limit = 10 * n + 20;
        while (((ap < n) || (dp >= 0)) && (guard < limit)) begin
            if (ap < n) begin
                hsel[d] = 1'b1; htrans[d] = q[ap].trans; haddr[d] = q[ap].addr;
                hwrite[d] = q[ap].write; hsize[d] = q[ap].size;
                hburst[d] = q[ap].burst; hprot[d] = q[ap].prot;
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00;
            end
            hwdata[d] = (dp >= 0) ? q[dp].wdata : 32'h0;
            @(negedge clk);
            rdy = (d == 0) ? hro_0 : hro_1;
            rsp = (d == 0) ? hresp_0 : hresp_1;
            rd  = (d == 0) ? hrdata_0 : hrdata_1;
            if (dp >= 0) begin
                if (!rdy) begin
                    res_low[dp] = res_low[dp] + 1;
                    if (rsp) res_errl[dp] = 1'b1;
                end else begin
                    res_rd[dp]   = rd;
                    res_errf[dp] = rsp;
                end
            end
            if (rdy) begin
                dp = (ap < n) ? ap : -1;
                if (ap < n) ap++;
            end
            @(posedge clk); #1;
            guard++;
        end
        hsel[d] = 1'b0; htrans[d] = 2'b00;
        checks++;
        if (guard >= limit) begin
            errors++;
            $display("FAIL run_seq_timeout dut%0d: cycles %0d, limit %0d", d, guard, limit);
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            hreset[d] = 1'b1; hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = 32'h0;
            hwrite[d] = 1'b0; hsize[d] = 3'd0; hburst[d] = 3'd0; hprot[d] = 4'h0; hwdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (hro_0 !== 1'b1) begin errors++; $display("FAIL reset_hreadyout0: got %b expected 1", hro_0); end
        checks++; if (hresp_0 !== 1'b0) begin errors++; $display("FAIL reset_hresp0: got %b expected 0", hresp_0); end
        checks++; if (hrdata_0 !== 32'h0) begin errors++; $display("FAIL reset_hrdata0: got %h expected 0", hrdata_0); end
        checks++; if (hro_1 !== 1'b1) begin errors++; $display("FAIL reset_hreadyout1: got %b expected 1", hro_1); end
        checks++; if (hresp_1 !== 1'b0) begin errors++; $display("FAIL reset_hresp1: got %b expected 0", hresp_1); end
        checks++; if (hrdata_1 !== 32'h0) begin errors++; $display("FAIL reset_hrdata1: got %h expected 0", hrdata_1); end
        @(posedge clk); #1;
        hreset[0] = 1'b0; hreset[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic init_mem(input int d);
        xfer_t q[$];
        int e_low; logic e_err; logic [31:0] e_rd;
        for (int w = 0; w < 256; w++) q.push_back(mk(2'b10, 1'b1, 32'(w * 4), 3'd2, $urandom));
        run_seq(d, q);
        for (int i = 0; i < q.size(); i++) begin
            model_apply(d, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL init dut%0d[%0d] @%h: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         d, i, q[i].addr, res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
    endtask

    task automatic test_word_rw;
        xfer_t q[$];
        int e_low; logic e_err; logic [31:0] e_rd;
        q.push_back(mk(2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(2'b10, 1'b0, 32'h10, 3'd2, 32'h0));
        run_seq(0, q);
        for (int i = 0; i < q.size(); i++) begin
            model_apply(0, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL word_rw[%0d]: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         i, res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
        checks++;
        if (res_rd[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rw_value: got %h expected deadbeef", res_rd[1]); end
    endtask

    task automatic test_byte_lane;
        xfer_t q[$];
        int e_low; logic e_err; logic [31:0] e_rd;
        q.push_back(mk(2'b10, 1'b1, 32'h13, 3'd0, 32'hAA000000));
        q.push_back(mk(2'b10, 1'b0, 32'h10, 3'd2, 32'h0));
        q.push_back(mk(2'b10, 1'b1, 32'h22, 3'd1, 32'h5A5A0000));
        q.push_back(mk(2'b10, 1'b0, 32'h20, 3'd2, 32'h0));
        run_seq(0, q);
        for (int i = 0; i < q.size(); i++) begin
            model_apply(0, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL byte_lane[%0d]: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         i, res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
        checks++;
        if (res_rd[1] !== 32'hAAADBEEF) begin errors++; $display("FAIL byte_lane_value: got %h expected aaadbeef", res_rd[1]); end
    endtask

    task automatic test_errors;
        xfer_t q[$];
        int e_low; logic e_err; logic [31:0] e_rd;
        q.push_back(mk(2'b10, 1'b1, 32'h400, 3'd2, 32'h11111111));
        q.push_back(mk(2'b10, 1'b0, 32'h000, 3'd2, 32'h0));
        q.push_back(mk(2'b10, 1'b1, 32'h011, 3'd1, 32'h22222222));
        q.push_back(mk(2'b10, 1'b0, 32'h010, 3'd3, 32'h0));
        q.push_back(mk(2'b10, 1'b0, 32'h010, 3'd2, 32'h0));
        q.push_back(mk(2'b10, 1'b1, 32'h3FC, 3'd2, 32'h600DF00D));
        q.push_back(mk(2'b11, 1'b0, 32'h3FC, 3'd2, 32'h0));
        run_seq(0, q);
        for (int i = 0; i < q.size(); i++) begin
            model_apply(0, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL errors[%0d] @%h: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         i, q[i].addr, res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
        checks++;
        if (res_rd[4] !== 32'hAAADBEEF) begin errors++; $display("FAIL errors_mem_kept: got %h expected aaadbeef", res_rd[4]); end
    endtask

    task automatic test_burst_wait;
        xfer_t q[$];
        xfer_t x;
        int e_low, tot; logic e_err; logic [31:0] e_rd;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 4; b++) begin
                x = mk((b == 0) ? 2'b10 : 2'b11, (r == 0), 32'(32'h20 + 4 * b), 3'd2, 32'(b + 1));
                x.burst = 3'b011;
                q.push_back(x);
            end
        end
        run_seq(1, q);
        tot = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i < 4) tot += res_low[i] + 1;
            model_apply(1, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL burst[%0d]: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         i, res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
        checks++;
        if (tot !== 12) begin errors++; $display("FAIL burst_cycles: got %0d expected 12", tot); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (res_rd[4 + b] !== 32'(b + 1)) begin
                errors++; $display("FAIL burst_readback[%0d]: got %h expected %h", b, res_rd[4 + b], 32'(b + 1));
            end
        end
    endtask

    task automatic test_reset_mid;
        xfer_t q[$];
        int e_low; logic e_err; logic [31:0] e_rd;
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h40; hwrite[1] = 1'b1;
        hsize[1] = 3'd2; hburst[1] = 3'd0; hprot[1] = 4'b0011;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (hro_1 !== 1'b0) begin errors++; $display("FAIL reset_mid_wait: got hreadyout %b expected 0", hro_1); end
        hreset[1] = 1'b1;
        @(posedge clk); #1;
        hreset[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({hro_1, hresp_1} !== 2'b10) begin
            errors++; $display("FAIL reset_mid_after: got hreadyout/hresp %b%b expected 10", hro_1, hresp_1);
        end
        @(posedge clk); #1;
        q.push_back(mk(2'b10, 1'b0, 32'h40, 3'd2, 32'h0));
        run_seq(1, q);
        model_apply(1, q[0], e_low, e_err, e_rd);
        checks++;
        if ({8'(res_low[0]), res_errl[0], res_errf[0], res_rd[0]} !== {8'(e_low), e_err, e_err, e_rd}) begin
            errors++;
            $display("FAIL reset_mid_read: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                     res_low[0], res_errl[0], res_errf[0], res_rd[0], e_low, e_err, e_rd);
        end
    endtask

`ifdef AHB_LITE_PROT_EN
    task automatic test_prot;
        xfer_t q[$];
        xfer_t x;
        int e_low; logic e_err; logic [31:0] e_rd;
        x = mk(2'b10, 1'b1, 32'h300, 3'd2, 32'h0BADC0DE); x.prot = 4'b0001; q.push_back(x);
        q.push_back(mk(2'b10, 1'b0, 32'h300, 3'd2, 32'h0));
        x = mk(2'b10, 1'b1, 32'h2FC, 3'd2, 32'h12344321); x.prot = 4'b0001; q.push_back(x);
        x = mk(2'b10, 1'b1, 32'h300, 3'd2, 32'h87654321); x.prot = 4'b0010; q.push_back(x);
        q.push_back(mk(2'b10, 1'b0, 32'h300, 3'd2, 32'h0));
        run_seq(0, q);
        for (int i = 0; i < q.size(); i++) begin
            model_apply(0, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL prot[%0d] @%h: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         i, q[i].addr, res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
        checks++;
        if (res_errf[0] !== 1'b1) begin errors++; $display("FAIL prot_user_write: got hresp %b expected 1", res_errf[0]); end
    endtask
`endif

    task automatic test_random(input int d);
        xfer_t q[$];
        xfer_t x;
        int r, a, e_low; logic e_err; logic [31:0] e_rd;
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 99);
            x.trans = (r < 8) ? 2'b00 : (r < 12) ? 2'b01 : ((r & 1) ? 2'b11 : 2'b10);
            x.write = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 99) < 60) ? 3'd2 : 3'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 75) begin
                a = $urandom_range(0, 63);
                if (x.size <= 3'd2) a = a - (a % (1 << x.size));
            end else if (r < 88) begin
                a = $urandom_range(0, 1023);
            end else begin
                a = $urandom_range(1024, 2047);
            end
            x.addr  = 32'(a);
            x.burst = 3'($urandom_range(0, 7));
            x.prot  = 4'($urandom_range(0, 15));
            x.wdata = $urandom;
            q.push_back(x);
        end
        run_seq(d, q);
        for (int i = 0; i < q.size(); i++) begin
            model_apply(d, q[i], e_low, e_err, e_rd);
            checks++;
            if ({8'(res_low[i]), res_errl[i], res_errf[i], res_rd[i]} !== {8'(e_low), e_err, e_err, e_rd}) begin
                errors++;
                $display("FAIL random dut%0d[%0d] t=%b w=%b @%h s=%0d: got low=%0d err=%b/%b rd=%h, expected low=%0d err=%b rd=%h",
                         d, i, q[i].trans, q[i].write, q[i].addr, q[i].size,
                         res_low[i], res_errl[i], res_errf[i], res_rd[i], e_low, e_err, e_rd);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_mem(0);
        init_mem(1);
        test_word_rw();
        test_byte_lane();
        test_errors();
        test_burst_wait();
        test_reset_mid();
`ifdef AHB_LITE_PROT_EN
        test_prot();
`endif
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
